// File: rtl/if_id_skid_pkg.sv
// Shared IF/ID constants, occupancy state view and a small occupancy helper.
package if_id_skid_pkg;

  localparam int IF_ID_AW = 32;
  localparam int IF_ID_IW = 32;

  // Instruction presented to decode whenever the stage holds nothing.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // The buffer state is implicit in {main_v, skid_v}; this enum names it.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_BAD   = 2'b01,
    OCC_ONE   = 2'b10,
    OCC_FULL  = 2'b11
  } occ_state_e;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/if_id_skid_skid_reg.sv
// Generic DW-wide two-entry valid/ready skid buffer with flush.
// in_ready is taken straight from a flop, so the upstream never sees a
// combinational path from out_ready.
module skid_reg
  import if_id_skid_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  logic          main_v;
  logic          skid_v;
  logic [DW-1:0] main_d;
  logic [DW-1:0] skid_d;
  logic          push;
  logic          pop;
  occ_state_e    state;

  assign in_ready  = ~skid_v;
  assign push      = in_valid & in_ready;
  assign pop       = main_v & out_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign occupancy = occ_count(main_v, skid_v);
  assign state     = occ_state_e'({main_v, skid_v});

  // Valid flags: reset beats flush beats the normal fill/drain update.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v) begin
      if (push) main_v <= 1'b1;
    end else if (!skid_v) begin
      if (push && !pop) skid_v <= 1'b1;
      else if (!push && pop) main_v <= 1'b0;
    end else if (pop) begin
      skid_v <= 1'b0;
    end
  end

  // Payload registers only load on a push or skid-to-main move, never idle.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (!main_v) begin
        if (push) main_d <= in_data;
      end else if (!skid_v) begin
        if (push && pop) main_d <= in_data;
        else if (push) skid_d <= in_data;
      end else if (pop) begin
        main_d <= skid_d;
      end
    end
  end

  // A skid entry without a main entry would break FIFO ordering.
  skid_without_main : assert property (@(posedge clk) disable iff (rst) state != OCC_BAD);

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline stage: skid-buffered fetch-to-decode register with hold
// gating and NOP/reset-address substitution when the stage is empty.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int            AW       = IF_ID_AW,
  parameter int            IW       = IF_ID_IW,
  parameter logic [IW-1:0] NOP_INST = INST_NOP,
  parameter logic [AW-1:0] RST_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          hold_flag_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [AW-1:0] inst_addr_i,
  input  logic [IW-1:0] inst_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] inst_addr_o,
  output logic [IW-1:0] inst_o,
  output logic [1:0]    occupancy_o
);

  logic [AW+IW-1:0] in_data;
  logic [AW+IW-1:0] out_data;
  logic             core_valid;
  logic             core_ready;

  assign in_data    = {inst_addr_i, inst_i};
  assign core_ready = out_ready_i & ~hold_flag_i;

  skid_reg #(
    .DW(AW + IW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_data   (in_data),
    .out_valid (core_valid),
    .out_ready (core_ready),
    .out_data  (out_data),
    .occupancy (occupancy_o)
  );

  assign out_valid_o = core_valid;
  assign inst_o      = core_valid ? out_data[IW-1:0] : NOP_INST;
  assign inst_addr_o = core_valid ? out_data[AW+IW-1:IW] : RST_ADDR;

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid: directed scenarios plus random traffic,
// checked against a depth-2 FIFO reference model with a scoreboard queue.
module tb_if_id_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        hold_flag_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_o;
  logic [1:0]  occupancy_o;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [63:0] exp_q[$];
  bit          model_known = 1'b0;

  if_id_skid dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .hold_flag_i (hold_flag_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .inst_addr_i (inst_addr_i),
    .inst_i      (inst_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .inst_addr_o (inst_addr_o),
    .inst_o      (inst_o),
    .occupancy_o (occupancy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_inst(input logic [31:0] a);
    return (a << 8) | 32'h33;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; report whether ifetch's offer was taken.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic orq,
                               input logic hold, input logic fl, input logic r,
                               output logic acc);
    in_valid_i  = v;
    inst_addr_i = a;
    inst_i      = mk_inst(a);
    out_ready_i = orq;
    hold_flag_i = hold;
    flush_i     = fl;
    rst         = r;
    @(negedge clk);
    acc = v & in_ready_o;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic v, input logic [31:0] a,
                             input logic [31:0] i, input logic rdy, input logic [1:0] occ);
    cmp({name, ".out_valid"}, 64'(out_valid_o), 64'(v));
    cmp({name, ".inst_addr"}, 64'(inst_addr_o), 64'(a));
    cmp({name, ".inst"}, 64'(inst_o), 64'(i));
    cmp({name, ".in_ready"}, 64'(in_ready_o), 64'(rdy));
    cmp({name, ".occupancy"}, 64'(occupancy_o), 64'(occ));
  endtask

  // Monitor + reference model: the stage behaves as a 2-deep FIFO whose
  // head is shown to id; flush/reset empty it, flushed pushes are lost.
  always @(negedge clk) begin
    logic do_push;
    logic do_pop;
    int   sz;
    sz = exp_q.size();
    if (model_known) begin
      cmp("mon.occupancy", 64'(occupancy_o), 64'(sz));
      cmp("mon.in_ready", 64'(in_ready_o), 64'(sz < 2));
      cmp("mon.out_valid", 64'(out_valid_o), 64'(sz > 0));
      if (sz > 0) cmp("mon.head", {inst_addr_o, inst_o}, exp_q[0]);
      else        cmp("mon.nop", {inst_addr_o, inst_o}, {32'h0, NOP});
    end
    do_pop  = (sz > 0) && out_ready_i && !hold_flag_i;
    do_push = in_valid_i && (sz < 2);
    if (rst) begin
      exp_q.delete();
      model_known = 1'b1;
    end else if (model_known) begin
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({inst_addr_i, inst_i});
      end
    end
  end

  initial begin
    logic        acc;
    logic [31:0] next_addr;

    // Reset for two cycles.
    applyStimulus(0, 32'h0, 0, 0, 0, 1, acc);
    applyStimulus(0, 32'h0, 0, 0, 0, 1, acc);
    checkOutput("reset", 0, 32'h0, NOP, 1, 0);

    // Streaming at full throughput.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'(k * 4), 1, 0, 0, 0, acc);
      checkOutput("stream", 1, 32'(k * 4), mk_inst(32'(k * 4)), 1, 1);
    end
    applyStimulus(0, 32'h0, 1, 0, 0, 0, acc);
    checkOutput("stream_drain", 0, 32'h0, NOP, 1, 0);

    // Stall fill: hold from the second push, ifetch keeps offering 0x18.
    applyStimulus(1, 32'h10, 1, 0, 0, 0, acc);
    applyStimulus(1, 32'h14, 1, 1, 0, 0, acc);
    checkOutput("stall_fill", 1, 32'h10, mk_inst(32'h10), 0, 2);
    applyStimulus(1, 32'h18, 1, 1, 0, 0, acc);
    cmp("stall_18_refused", 64'(acc), 64'(0));
    checkOutput("stall_held", 1, 32'h10, mk_inst(32'h10), 0, 2);
    applyStimulus(1, 32'h18, 1, 0, 0, 0, acc);
    checkOutput("stall_rel1", 1, 32'h14, mk_inst(32'h14), 1, 1);
    applyStimulus(1, 32'h18, 1, 0, 0, 0, acc);
    checkOutput("stall_rel2", 1, 32'h18, mk_inst(32'h18), 1, 1);
    applyStimulus(0, 32'h0, 1, 0, 0, 0, acc);

    // Flush while full, with a push offered in the flush cycle.
    applyStimulus(1, 32'h30, 0, 1, 0, 0, acc);
    applyStimulus(1, 32'h34, 0, 1, 0, 0, acc);
    checkOutput("pre_flush", 1, 32'h30, mk_inst(32'h30), 0, 2);
    applyStimulus(1, 32'h20, 1, 1, 1, 0, acc);
    checkOutput("flush", 0, 32'h0, NOP, 1, 0);
    applyStimulus(0, 32'h0, 1, 0, 0, 0, acc);
    checkOutput("post_flush", 0, 32'h0, NOP, 1, 0);

    // Backpressure: out_ready toggling with continuous offers.
    next_addr = 32'h100;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, next_addr, (k % 2) == 0, 0, 0, 0, acc);
      if (acc) next_addr += 4;
    end
    for (int k = 0; k < 3; k++) applyStimulus(0, 32'h0, 1, 0, 0, 0, acc);

    // Reset while full, together with flush and a push.
    applyStimulus(1, 32'h50, 0, 0, 0, 0, acc);
    applyStimulus(1, 32'h54, 0, 0, 0, 0, acc);
    checkOutput("pre_reset_full", 1, 32'h50, mk_inst(32'h50), 0, 2);
    applyStimulus(1, 32'h40, 1, 0, 1, 1, acc);
    checkOutput("reset_full", 0, 32'h0, NOP, 1, 0);
    applyStimulus(1, 32'h44, 0, 0, 0, 0, acc);
    checkOutput("after_reset", 1, 32'h44, mk_inst(32'h44), 1, 1);
    applyStimulus(0, 32'h0, 1, 0, 0, 0, acc);

    // Random traffic.
    next_addr = 32'h1000;
    for (int k = 0; k < 2000; k++) begin
      applyStimulus($urandom_range(0, 3) != 0, next_addr, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 59) == 0, acc);
      if (acc) next_addr += 4;
    end
    for (int k = 0; k < 4; k++) applyStimulus(0, 32'h0, 1, 0, 0, 0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised IF/ID pipeline stage with a valid/ready handshake, replacing the plain hold/flush register pair.
- Holds a 2-entry skid buffer (main + skid), so ifetch sees a fully registered ready and never loses an instruction fetched in the cycle a stall begins.
- Flush clears both entries; an empty stage drives a NOP to id.
- Sits between ifetch (upstream), id (downstream) and ctrl (hold/flush).

Parameters:
- AW, 32, instruction address width.
- IW, 32, instruction width.
- NOP_INST, 32'h0000_0013, instruction driven on inst_o when out_valid_o=0 (same value as the shared INST_NOP define).
- RST_ADDR, 32'h0, address driven on inst_addr_o when out_valid_o=0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  from ctrl; discard all buffered and incoming entries.
- hold_flag_i  in  1  from ctrl; freeze output (acts as downstream not-ready).
- in_valid_i  in  1  ifetch presents an instruction.
- in_ready_o  out  1  stage can accept; registered.
- inst_addr_i  in  AW  fetched instruction address.
- inst_i  in  IW  fetched instruction.
- out_valid_o  out  1  main entry valid.
- out_ready_i  in  1  id can consume.
- inst_addr_o  out  AW  to id.
- inst_o  out  IW  to id.
- occupancy_o  out  2  entries held (0..2), for ctrl/debug.

Behaviour:
- State: main_v, main_{addr,inst}, skid_v, skid_{addr,inst}.
- Invariant: skid_v=1 implies main_v=1.
- Definitions:
  - push = in_valid_i & in_ready_o.
  - pop = main_v & out_ready_i & ~hold_flag_i.
- in_ready_o = ~skid_v; this is a register output, so there is no combinational path from out_ready_i or hold_flag_i.
- Outputs:
  - out_valid_o = main_v.
  - inst_o = main_v ? main_inst : NOP_INST.
  - inst_addr_o = main_v ? main_addr : RST_ADDR.
  - occupancy_o = main_v + skid_v.
- Priority per edge: rst > flush_i > normal update.
- Reset (rst=1 at edge):
  - main_v=0, skid_v=0.
  - Outputs next cycle: out_valid_o=0, inst_o=NOP_INST, inst_addr_o=RST_ADDR, in_ready_o=1, occupancy_o=0.
  - Reset mid-operation discards held entries identically.
- Flush (flush_i=1, rst=0):
  - main_v=0, skid_v=0.
  - A push in the same cycle is dropped; a pop in the same cycle still counts as consumed by id.
  - NOP visible the next cycle.
  - Data registers need not clear.
- Normal update, by case:
  - Empty (main_v=0), push: load main. Output valid after 1 cycle (fall-through latency 1).
  - main_v=1, skid_v=0, push & pop: main <= input. Full throughput, 1 instr/cycle.
  - main_v=1, skid_v=0, push & ~pop: skid <= input, skid_v=1. in_ready_o drops the next cycle.
  - main_v=1, skid_v=0, ~push & pop: main_v=0.
  - skid_v=1, pop: main <= skid, skid_v=0. push is impossible here (in_ready_o=0).
  - skid_v=1, ~pop: hold everything.
- hold_flag_i=1: output and buffer content frozen, pushes still accepted until full. Upstream stalls at most 1 cycle later.
- Data registers load only on a push/move, so no toggling occurs on idle cycles.
- The FSM is implicit in (main_v, skid_v): EMPTY(0,0), ONE(1,0), FULL(1,1). (0,1) is unreachable; an assertion flags it.
- No arithmetic, no width conversion. Ordering is strictly FIFO.

Decomposition:
- Shared defines: NOP_INST value (existing INST_NOP) and the IF/ID payload width constants (AW/IW defaults).
- One natural sub-module: skid_reg, a generic DW-wide 2-entry valid/ready skid buffer with flush.
  - if_id_skid instantiates it with DW=AW+IW on the concatenation {addr,inst}.
  - It adds the NOP/RST_ADDR output muxing and hold gating.

Test Plan:
- Reset: rst=1 for 2 cycles, then in_valid_i=0 -> out_valid_o=0, inst_o=32'h00000013, inst_addr_o=0, in_ready_o=1, occupancy_o=0.
- Streaming: push addr 0x0,0x4,0x8,0xC on consecutive cycles with out_ready_i=1 -> same sequence on inst_addr_o one cycle later; in_ready_o stays 1 and there are no bubbles.
- Stall fill: push 0x10,0x14,0x18 with hold_flag_i=1 from the 2nd push -> 0x10 held on output, 0x14 in skid, occupancy_o=2, in_ready_o=0. 0x18 is held by ifetch, not dropped. After hold release the output order is 0x10,0x14,0x18.
- Flush while full: occupancy_o=2, then flush_i=1 with in_valid_i=1 addr 0x20 -> next cycle out_valid_o=0, inst_o=NOP, occupancy_o=0, in_ready_o=1. 0x20 never appears.
- Backpressure: out_ready_i toggling 1,0,1,0 with continuous pushes -> every pushed address appears exactly once, in order. occupancy_o never exceeds 2 and never reaches (main_v=0, skid_v=1).
- Reset during FULL, simultaneous with flush_i=1 and push -> reset state next cycle; the first push after reset appears with latency 1.
